// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with overlap select, valid-qualified input and saturating match counter.
// Optional per-bit don't-care mask on the pattern compare is enabled by defining SEQDET_MASK_EN.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             overlap,
    input  logic             d_valid,
    input  logic             d_in,
    input  logic             cnt_clr,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask_in,
`endif
    output logic             pattern_detect,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_ok
);

    typedef enum logic [1:0] {UNCFG, HUNT, DETECT} state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   pattern, pattern_n;
    logic [LEN_W-1:0]   length, length_n;
    // Only PAT_W-1 old bits need storing; the newest bit completes the compare window.
    logic [PAT_W-2:0]   history, history_n;
    logic [LEN_W-1:0]   fill, fill_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [PAT_W-1:0]   mask_q;
    logic [PAT_W-1:0]   len_mask;
    logic [PAT_W-1:0]   shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic               match;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0]   mask_n;
`else
    assign mask_q = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= UNCFG;
            pattern <= '0;
            length  <= '0;
            history <= '0;
            fill    <= '0;
            count   <= '0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            state   <= state_n;
            pattern <= pattern_n;
            length  <= length_n;
            history <= history_n;
            fill    <= fill_n;
            count   <= count_n;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_n;
`endif
        end
    end

    // Select the low 'length' bits of the window for comparison.
    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(length));
        end
    end

    always_comb begin
        state_n   = state;
        pattern_n = pattern;
        length_n  = length;
        history_n = history;
        fill_n    = fill;
        count_n   = count;
        match     = 1'b0;
`ifdef SEQDET_MASK_EN
        mask_n    = mask_q;
`endif
        shifted   = {history, d_in};
        fill_inc  = (fill < LEN_W'(PAT_W)) ? fill + 1'b1 : fill;

        if (cfg_we) begin
            pattern_n = pat_in;
            length_n  = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
            history_n = '0;
            fill_n    = '0;
`ifdef SEQDET_MASK_EN
            mask_n    = pat_mask_in;
`endif
            state_n   = (length_n != '0) ? HUNT : UNCFG;
        end else if (state != UNCFG) begin
            if (d_valid) begin
                history_n = shifted[PAT_W-2:0];
                fill_n    = fill_inc;
                match     = (fill_inc >= length) &&
                            (((shifted ^ pattern) & len_mask & mask_q) == '0);
                // Non-overlapping mode: bits of a matched window may not be reused.
                if (match && !overlap) begin
                    fill_n = '0;
                end
            end
            state_n = match ? DETECT : HUNT;
        end

        if (cnt_clr) begin
            count_n = '0;
        end else if (match && (count != '1)) begin
            count_n = count + 1'b1;
        end
    end

    assign pattern_detect = (state == DETECT);
    assign cfg_ok         = (state != UNCFG);
    assign match_count    = count;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (default build, 2-bit counter to reach saturation quickly).
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic             overlap;
    logic             d_valid;
    logic             d_in;
    logic             cnt_clr;
    logic             pattern_detect;
    logic [CNT_W-1:0] match_count;
    logic             cfg_ok;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .pat_in         (pat_in),
        .len_in         (len_in),
        .overlap        (overlap),
        .d_valid        (d_valid),
        .d_in           (d_in),
        .cnt_clr        (cnt_clr),
        .pattern_detect (pattern_detect),
        .match_count    (match_count),
        .cfg_ok         (cfg_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock with the given data/clear inputs; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic d, input logic clr);
        d_valid = v;
        d_in    = d;
        cnt_clr = clr;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_in    = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic configure(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len);
        cfg_we = 1'b1;
        pat_in = pat;
        len_in = len;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // bits[n-1] is sent first; exp[i] is the detect value expected after sending bits[i].
    task automatic runStream(input string name, input logic [15:0] bits, input logic [15:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i], 1'b0);
            checkOutput($sformatf("%s bit%0d", name, n - i), int'(pattern_detect), int'(exp[i]));
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; pat_in = '0; len_in = '0; overlap = 1'b0;
        d_valid = 1'b0; d_in = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset detect", int'(pattern_detect), 0);
        checkOutput("reset count", int'(match_count), 0);
        checkOutput("reset cfg_ok", int'(cfg_ok), 0);
        rst = 1'b0;

        $display("[TB] test 1: non-overlapping 1011");
        overlap = 1'b0;
        configure(8'b0000_1011, 4'd4);
        checkOutput("t1 cfg_ok", int'(cfg_ok), 1);
        runStream("t1", 16'b1011011, 16'b0001000, 7);
        checkOutput("t1 count", int'(match_count), 1);

        $display("[TB] test 2: overlapping 1011");
        overlap = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        configure(8'b0000_1011, 4'd4);
        runStream("t2", 16'b1011011, 16'b0001001, 7);
        checkOutput("t2 count", int'(match_count), 2);

        $display("[TB] test 3: overlapping 11 held");
        applyStimulus(1'b0, 1'b0, 1'b1);
        configure(8'b0000_0011, 4'd2);
        runStream("t3", 16'b1111, 16'b0111, 4);
        checkOutput("t3 count", int'(match_count), 3);

        $display("[TB] test 4: gaps in the stream");
        overlap = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        configure(8'b0000_1011, 4'd4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4 gap detect", int'(pattern_detect), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4 pre-last detect", int'(pattern_detect), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4 last detect", int'(pattern_detect), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4 pulse drop", int'(pattern_detect), 0);
        checkOutput("t4 count", int'(match_count), 1);

        $display("[TB] test 5: counter saturation and clear priority");
        overlap = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        configure(8'b0000_0011, 4'd2);
        runStream("t5", 16'b111111, 16'b011111, 6);
        checkOutput("t5 saturated count", int'(match_count), 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t5 clr+match detect", int'(pattern_detect), 1);
        checkOutput("t5 clr+match count", int'(match_count), 0);

        $display("[TB] test 6: zero length and mid-stream reset");
        configure(8'b0000_0011, 4'd0);
        checkOutput("t6 len0 cfg_ok", int'(cfg_ok), 0);
        runStream("t6 len0", 16'b1111, 16'b0000, 4);
        overlap = 1'b0;
        configure(8'b0000_1011, 4'd4);
        runStream("t6 pre", 16'b101, 16'b000, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6 rst cfg_ok", int'(cfg_ok), 0);
        checkOutput("t6 rst count", int'(match_count), 0);
        configure(8'b0000_1011, 4'd4);
        checkOutput("t6 recfg cfg_ok", int'(cfg_ok), 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t6 final bit", int'(pattern_detect), 0);

        $display("[TB] test 7: length clamps to PAT_W");
        configure(8'hA5, 4'd15);
        runStream("t7", 16'hA5, 16'h01, 8);
        checkOutput("t7 count", int'(match_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
